// File: rtl/md_unit.sv
// Multicycle multiply/divide unit owning the architectural HI/LO registers.
// Results are committed after a fixed latency; flush cancels in-flight work.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count, count_next;
  logic [1:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic          load;
  logic          done_next;
  logic [31:0]   hi_next, lo_next;

  // Datapath operates on the latched operands only.
  logic [63:0] ext_a, ext_b, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;
  logic [31:0] res_hi, res_lo;

  always_comb begin
    // op[0]=0 selects the signed variants.
    ext_a  = op_q[0] ? {32'd0, a_q} : {{32{a_q[31]}}, a_q};
    ext_b  = op_q[0] ? {32'd0, b_q} : {{32{b_q[31]}}, b_q};
    prod   = ext_a * ext_b;
    a_neg  = !op_q[0] && a_q[31];
    b_neg  = !op_q[0] && b_q[31];
    a_mag  = a_neg ? -a_q : a_q;
    b_mag  = b_neg ? -b_q : b_q;
    // Zero divisor never commits; substitute 1 to keep the divider well defined.
    b_div  = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_div;
    r_mag  = a_mag % b_div;
    quot   = (a_neg ^ b_neg) ? -q_mag : q_mag;
    rem    = a_neg ? -r_mag : r_mag;
    res_hi = op_q[1] ? rem  : prod[63:32];
    res_lo = op_q[1] ? quot : prod[31:0];
  end

  always_comb begin
    state_next = state;
    count_next = count;
    load       = 1'b0;
    done_next  = 1'b0;
    hi_next    = hi;
    lo_next    = lo;
    if (flush) begin
      state_next = IDLE;
      count_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            load       = 1'b1;
            count_next = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            state_next = RUN;
          end else begin
            if (mthi) hi_next = rs_data;
            if (mtlo) lo_next = rs_data;
          end
        end
        RUN: begin
          if (count <= CW'(1)) begin
            state_next = IDLE;
            count_next = '0;
            done_next  = 1'b1;
            if (!(op_q[1] && b_q == 32'd0)) begin
              hi_next = res_hi;
              lo_next = res_lo;
            end
          end else begin
            count_next = count - CW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_next;
      count <= count_next;
      done  <= done_next;
      hi    <= hi_next;
      lo    <= lo_next;
      if (load) begin
        op_q <= op;
        a_q  <= rs_data;
        b_q  <= rt_data;
      end
    end
  end

  assign busy = (state == RUN);

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 The block SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for MULT/MULTU.
REQ-002 The block SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for DIV/DIVU.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: the decode stage requests a multiply or divide.
REQ-006 The block SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-007 The block SHALL have ports rs_data and rt_data, input, 32 bits each: the source operands.
REQ-008 The block SHALL have ports mthi and mtlo, input, 1 bit each: write rs_data into HI or LO respectively.
REQ-009 The block SHALL have port flush, input, 1 bit: exception or ERET cancels any in-flight operation.
REQ-010 The block SHALL have port busy, output, 1 bit: an operation is in flight.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO are committed.
REQ-012 The block SHALL have ports hi and lo, output, 32 bits each: the architectural HI and LO registers, read directly by MFHI/MFLO.

Function
REQ-013 The block SHALL implement two states: IDLE and RUN.
REQ-014 In IDLE with start=1 at an edge, the block SHALL latch op, rs_data and rt_data, load the counter with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-015 busy SHALL equal 1 exactly while in RUN, i.e. for N consecutive cycles after the start edge, where N is the latency selected by op.
REQ-016 At the edge ending the Nth RUN cycle, the block SHALL write the result to HI/LO, return to IDLE, and assert done for exactly one cycle.
REQ-017 For MULT the block SHALL compute the signed 64-bit product and for MULTU the unsigned 64-bit product, with HI = bits 63:32 and LO = bits 31:0.
REQ-018 For DIV the block SHALL compute a signed quotient truncated toward zero, with the remainder taking the sign of the dividend; LO = quotient and HI = remainder.
REQ-019 For DIVU the block SHALL compute the unsigned quotient into LO and the remainder into HI.
REQ-020 For DIV, 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-021 For a divisor of zero, the block SHALL run the full DIV_CYCLES and pulse done, but SHALL leave HI and LO unchanged.
REQ-022 start asserted while busy=1 SHALL be ignored; the in-flight operation SHALL be unaffected.
REQ-023 In IDLE, mthi=1 SHALL load HI from rs_data at the edge, and mtlo=1 SHALL load LO from rs_data; both may be asserted in the same cycle.
REQ-024 mthi and mtlo asserted while busy=1 SHALL be ignored.
REQ-025 If start and mthi/mtlo are asserted in the same IDLE cycle, start SHALL win and the move SHALL be ignored.
REQ-026 flush=1 at any edge SHALL force IDLE and deassert busy and done without touching HI/LO; start, mthi and mtlo SHALL be ignored in that cycle.
REQ-027 If flush coincides with the completion edge, flush SHALL win: no HI/LO write and no done pulse.
REQ-028 The counter SHALL be wide enough for max(MULT_CYCLES, DIV_CYCLES); both parameters SHALL be at least 1.

Reset
REQ-029 Asserting reset SHALL immediately, without waiting for a clock edge, force IDLE, busy=0, done=0, hi=0, lo=0 and counter=0, including in the middle of an operation.
REQ-030 After reset deasserts, the first clock edge SHALL be able to accept start.

Verification
REQ-031 Bench SHALL cover: MULT with rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy high for 5 cycles, then done pulse, hi=0xFFFFFFFF, lo=0xFFFFFFFA; the same operands with MULTU -> hi=0x00000002, lo=0xFFFFFFFA.
REQ-032 Bench SHALL cover: DIV with rs=0xFFFFFFF9 (-7), rt=0x00000002 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU with 0x80000000 / 0xFFFFFFFF -> lo=0x00000000, hi=0x80000000.
REQ-033 Bench SHALL cover: HI/LO preset to 0x11111111/0x22222222, then DIV by 0 -> done pulses after 10 cycles and HI/LO keep 0x11111111/0x22222222.
REQ-034 Bench SHALL cover: start a DIV, then assert start, mthi and mtlo during busy -> all ignored and the original quotient is committed at cycle 10.
REQ-035 Bench SHALL cover: start a MULT and flush at RUN cycle 3 -> busy=0 next cycle, no done, HI/LO unchanged; then a new MULT starts cleanly on the following cycle.
REQ-036 Bench SHALL cover: assert reset asynchronously mid-DIV -> busy, done, hi and lo read 0 before the next clock edge.
